// File: rtl/ipv4_vlg_rx.sv
// rtl/ipv4_vlg_rx.sv - IPv4 receive parser: header check, payload framing, padding strip
//
// Purpose: consumes the MAC payload stream of ethertype 0x0800 frames, parses and
// validates the 20..60 byte IPv4 header, then forwards exactly length - IHL*4
// payload bytes (one cycle after input) and discards Ethernet padding.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   dev_ipv4          local IPv4 address
//   mac_*             MAC payload stream (dat/val/sof/eof/err) and frame ethertype
//   hdr, hdr_val      parsed 160-bit header (byte 0 in [159:152]) and accept pulse
//   pld_*             payload stream (dat/val/sof/eof/err)
//   drop, drop_cause  discard pulse and reason (1 ver/IHL, 2 checksum, 3 dst,
//                     4 truncated header, 5 mac_err in header)
module ipv4_vlg_rx #(
  parameter bit VERIFY_CHSUM = 1'b1,
  parameter bit ACCEPT_BCAST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dev_ipv4,
  input  logic [7:0]   mac_dat,
  input  logic         mac_val,
  input  logic         mac_sof,
  input  logic         mac_eof,
  input  logic         mac_err,
  input  logic [15:0]  mac_ethertype,
  output logic [159:0] hdr,
  output logic         hdr_val,
  output logic [7:0]   pld_dat,
  output logic         pld_val,
  output logic         pld_sof,
  output logic         pld_eof,
  output logic         pld_err,
  output logic         drop,
  output logic [2:0]   drop_cause
);

  typedef enum logic [2:0] {idle_s, hdr_s, opt_s, pld_s, skip_s} state_t;

  localparam logic [15:0] ETH_IPV4       = 16'h0800;
  localparam logic [31:0] IPV4_BROADCAST = 32'hFFFF_FFFF;
  localparam logic [2:0]  C_HDR    = 3'd1;
  localparam logic [2:0]  C_CHSUM  = 3'd2;
  localparam logic [2:0]  C_DST    = 3'd3;
  localparam logic [2:0]  C_TRUNC  = 3'd4;
  localparam logic [2:0]  C_MACERR = 3'd5;

  state_t         state, state_n;
  logic [159:0]   hdr_sh, hdr_sh_n, hdr_n;
  logic [31:0]    sum, sum_n;
  logic [7:0]     hi, hi_n;       // high byte of the 16-bit word in progress
  logic [5:0]     cnt, cnt_n;     // header byte index (options included)
  logic [3:0]     ihl, ihl_n;
  logic [15:0]    rem, rem_n;     // payload bytes still to forward
  logic           first, first_n;
  logic           hdr_val_n, pld_val_n, pld_sof_n, pld_eof_n, pld_err_n, drop_n;
  logic [7:0]     pld_dat_n;
  logic [2:0]     drop_cause_n;

  // Header-complete view: includes the byte being consumed this cycle so the
  // acceptance decision is registered on the same edge as the last header byte.
  logic [5:0]     hdr_len;
  logic           last_hdr;
  logic [159:0]   hdr_full;
  logic [31:0]    sum_full;
  logic [16:0]    fold1;
  logic [15:0]    fold2;
  logic [15:0]    tot_len, pl_len;
  logic [31:0]    dst_ip;
  logic           chk_ok, dst_ok;

  assign hdr_len  = {ihl, 2'b00};
  assign last_hdr = (cnt == hdr_len - 6'd1);
  // Options are never shifted in, so in opt_s the register already holds bytes 0..19.
  assign hdr_full = (state == hdr_s) ? {hdr_sh[151:0], mac_dat} : hdr_sh;
  assign sum_full = sum + {16'd0, hi, mac_dat};
  // At most 30 words are summed, so two folds always leave 16 bits.
  assign fold1    = {1'b0, sum_full[15:0]} + {1'b0, sum_full[31:16]};
  assign fold2    = fold1[15:0] + {15'd0, fold1[16]};
  assign chk_ok   = !VERIFY_CHSUM || (fold2 == 16'hFFFF);
  assign dst_ip   = hdr_full[31:0];
  assign dst_ok   = (dst_ip == dev_ipv4) || (ACCEPT_BCAST && (dst_ip == IPV4_BROADCAST));
  assign tot_len  = hdr_full[143:128];
  // A total length shorter than the header is treated as an empty payload.
  assign pl_len   = (tot_len > {10'd0, hdr_len}) ? (tot_len - {10'd0, hdr_len}) : 16'd0;

  always_comb begin
    state_n      = state;
    hdr_sh_n     = hdr_sh;
    hdr_n        = hdr;
    sum_n        = sum;
    hi_n         = hi;
    cnt_n        = cnt;
    ihl_n        = ihl;
    rem_n        = rem;
    first_n      = first;
    pld_dat_n    = pld_dat;
    hdr_val_n    = 1'b0;
    pld_val_n    = 1'b0;
    pld_sof_n    = 1'b0;
    pld_eof_n    = 1'b0;
    pld_err_n    = 1'b0;
    drop_n       = 1'b0;
    drop_cause_n = 3'd0;

    if (mac_val && mac_sof) begin
      // A new frame aborts whatever was in flight. In pld_s there is no byte to
      // carry the abort, so pld_eof/pld_err are flagged without pld_val.
      if (state == pld_s) begin
        pld_eof_n = 1'b1;
        pld_err_n = 1'b1;
      end else if (state == hdr_s || state == opt_s) begin
        drop_n       = 1'b1;
        drop_cause_n = C_TRUNC;
      end
      state_n = idle_s;
      if (mac_ethertype == ETH_IPV4) begin
        hdr_sh_n = {hdr_sh[151:0], mac_dat};
        hi_n     = mac_dat;
        sum_n    = 32'd0;
        cnt_n    = 6'd1;
        ihl_n    = mac_dat[3:0];
        if (mac_dat[7:4] != 4'd4 || mac_dat[3:0] < 4'd5) begin
          if (!drop_n) begin
            drop_n       = 1'b1;
            drop_cause_n = C_HDR;
          end
          state_n = mac_eof ? idle_s : skip_s;
        end else if (mac_eof) begin
          if (!drop_n) begin
            drop_n       = 1'b1;
            drop_cause_n = mac_err ? C_MACERR : C_TRUNC;
          end
        end else begin
          state_n = hdr_s;
        end
      end
    end else if (mac_val) begin
      case (state)
        hdr_s, opt_s: begin
          if (state == hdr_s) hdr_sh_n = hdr_full;
          if (!cnt[0]) hi_n = mac_dat;
          else         sum_n = sum_full;
          cnt_n = cnt + 6'd1;
          if (last_hdr) begin
            state_n = mac_eof ? idle_s : skip_s;
            if (mac_eof && mac_err) begin
              drop_n       = 1'b1;
              drop_cause_n = C_MACERR;
            end else if (!chk_ok) begin
              drop_n       = 1'b1;
              drop_cause_n = C_CHSUM;
            end else if (!dst_ok) begin
              drop_n       = 1'b1;
              drop_cause_n = C_DST;
            end else if (mac_eof && pl_len != 16'd0) begin
              drop_n       = 1'b1;
              drop_cause_n = C_TRUNC;
            end else begin
              hdr_val_n = 1'b1;
              hdr_n     = hdr_full;
              rem_n     = pl_len;
              first_n   = 1'b1;
              if (pl_len != 16'd0) state_n = pld_s;
            end
          end else if (mac_eof) begin
            drop_n       = 1'b1;
            drop_cause_n = mac_err ? C_MACERR : C_TRUNC;
            state_n      = idle_s;
          end else if (cnt == 6'd19) begin
            state_n = opt_s;
          end
        end
        pld_s: begin
          pld_val_n = 1'b1;
          pld_dat_n = mac_dat;
          pld_sof_n = first;
          first_n   = 1'b0;
          rem_n     = rem - 16'd1;
          if (rem == 16'd1) begin
            pld_eof_n = 1'b1;
            pld_err_n = mac_eof & mac_err;
            state_n   = mac_eof ? idle_s : skip_s;
          end else if (mac_eof) begin
            pld_eof_n = 1'b1;
            pld_err_n = 1'b1;
            state_n   = idle_s;
          end
        end
        skip_s: begin
          if (mac_eof) state_n = idle_s;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= idle_s;
      hdr_sh     <= '0;
      hdr        <= '0;
      sum        <= '0;
      hi         <= '0;
      cnt        <= '0;
      ihl        <= '0;
      rem        <= '0;
      first      <= 1'b0;
      hdr_val    <= 1'b0;
      pld_dat    <= '0;
      pld_val    <= 1'b0;
      pld_sof    <= 1'b0;
      pld_eof    <= 1'b0;
      pld_err    <= 1'b0;
      drop       <= 1'b0;
      drop_cause <= '0;
    end else begin
      state      <= state_n;
      hdr_sh     <= hdr_sh_n;
      hdr        <= hdr_n;
      sum        <= sum_n;
      hi         <= hi_n;
      cnt        <= cnt_n;
      ihl        <= ihl_n;
      rem        <= rem_n;
      first      <= first_n;
      hdr_val    <= hdr_val_n;
      pld_dat    <= pld_dat_n;
      pld_val    <= pld_val_n;
      pld_sof    <= pld_sof_n;
      pld_eof    <= pld_eof_n;
      pld_err    <= pld_err_n;
      drop       <= drop_n;
      drop_cause <= drop_cause_n;
    end
  end

endmodule
